div64_iter: RTL and testbench

Iterative 64-bit integer divider built on repeated trial subtraction, one quotient bit per cycle. It is a multi-cycle functional unit in the out-of-order execution stage and carries a tag alongside each operation. Each operation yields both quotient and remainder. Signed and unsigned division are supported. Divide-by-zero and signed overflow produce deterministic results and never trap.

---
 rtl/div64_iter.sv | 168 ++++++++++++++++
 tb/tb_div64_iter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div64_iter.sv
// Iterative 64-bit signed/unsigned divider: one restoring-division quotient bit per cycle,
// fixed 65-cycle latency, tag carried alongside, deterministic divide-by-zero/overflow results.
module div64_iter #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [63:0]      dividend,
    input  logic [63:0]      divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      quotient,
    output logic [63:0]      remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [64:0]        rem_q, rem_d;
    logic [63:0]        dvd_q, dvd_d;
    logic [63:0]        dsr_q, dsr_d;
    logic [63:0]        orig_q, orig_d;
    logic [6:0]         cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               neg_q_flag_q, neg_q_flag_d;
    logic               neg_r_flag_q, neg_r_flag_d;
    logic               zero_q, zero_d;
    logic [63:0]        quot_out_q, quot_out_d;
    logic [63:0]        rem_out_q, rem_out_d;
    logic [TAG_W-1:0]   tag_out_q, tag_out_d;
    logic               dbz_out_q, dbz_out_d;

    logic               sgn_a, sgn_b;
    logic [64:0]        shifted, trial;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready and out_valid are pure functions of state.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_out_q;
    assign remainder   = rem_out_q;
    assign out_tag     = tag_out_q;
    assign div_by_zero = dbz_out_q;
    assign dbg_state   = state_q;

    always_comb begin
        sgn_a   = in_signed & dividend[63];
        sgn_b   = in_signed & divisor[63];
        shifted = {rem_q[63:0], dvd_q[63]};
        trial   = shifted - {1'b0, dsr_q};

        state_d      = state_q;
        rem_d        = rem_q;
        dvd_d        = dvd_q;
        dsr_d        = dsr_q;
        orig_d       = orig_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        neg_q_flag_d = neg_q_flag_q;
        neg_r_flag_d = neg_r_flag_q;
        zero_d       = zero_q;
        quot_out_d   = quot_out_q;
        rem_out_d    = rem_out_q;
        tag_out_d    = tag_out_q;
        dbz_out_d    = dbz_out_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d        = sgn_a ? (~dividend + 64'd1) : dividend;
                    dsr_d        = sgn_b ? (~divisor + 64'd1) : divisor;
                    orig_d       = dividend;
                    tag_d        = in_tag;
                    neg_q_flag_d = sgn_a ^ sgn_b;
                    neg_r_flag_d = sgn_a;
                    zero_d       = (divisor == 64'd0);
                    rem_d        = 65'd0;
                    cnt_d        = 7'd64;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                // Borrow out of the 65-bit trial means the shifted remainder was below the divisor.
                if (!trial[64]) begin
                    rem_d = trial;
                end else begin
                    rem_d = shifted;
                end
                dvd_d = {dvd_q[62:0], ~trial[64]};
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                // MIN / -1 falls out naturally: magnitude 2^63 negated wraps back to 2^63.
                if (zero_q) begin
                    quot_out_d = '1;
                    rem_out_d  = orig_q;
                end else begin
                    quot_out_d = neg_q_flag_q ? (~dvd_q + 64'd1) : dvd_q;
                    rem_out_d  = neg_r_flag_q ? (~rem_q[63:0] + 64'd1) : rem_q[63:0];
                end
                tag_out_d = tag_q;
                dbz_out_d = zero_q;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            dvd_q        <= '0;
            dsr_q        <= '0;
            orig_q       <= '0;
            cnt_q        <= '0;
            tag_q        <= '0;
            neg_q_flag_q <= 1'b0;
            neg_r_flag_q <= 1'b0;
            zero_q       <= 1'b0;
            quot_out_q   <= '0;
            rem_out_q    <= '0;
            tag_out_q    <= '0;
            dbz_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            dvd_q        <= dvd_d;
            dsr_q        <= dsr_d;
            orig_q       <= orig_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            neg_q_flag_q <= neg_q_flag_d;
            neg_r_flag_q <= neg_r_flag_d;
            zero_q       <= zero_d;
            quot_out_q   <= quot_out_d;
            rem_out_q    <= rem_out_d;
            tag_out_q    <= tag_out_d;
            dbz_out_q    <= dbz_out_d;
        end
    end

endmodule

// File: tb/tb_div64_iter.sv
// Self-checking bench for div64_iter: directed corner cases plus random operands checked
// against an arithmetic reference model, with latency, backpressure, flush and reset checks.
module tb_div64_iter;

    localparam int TAG_W = 6;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [63:0]      dividend;
    logic [63:0]      divisor;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      quotient;
    logic [63:0]      remainder;
    logic [TAG_W-1:0] out_tag;
    logic             div_by_zero;
    logic [1:0]       dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    div64_iter #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .out_tag     (out_tag),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic from the division rules.
    task automatic ref_div(input logic sg, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] q, output logic [63:0] r, output logic z);
        longint sa, sb;
        z = (b == 64'd0);
        if (z) begin
            q = '1;
            r = a;
        end else if (!sg) begin
            q = a / b;
            r = a % b;
        end else if (a == MIN64 && b == '1) begin
            q = MIN64;
            r = 64'd0;
        end else begin
            sa = a;
            sb = b;
            q = 64'(sa / sb);
            r = 64'(sa % sb);
        end
    endtask

    // Issues one op from the IDLE state, checks latency, result, backpressure and release.
    task automatic run_op(input logic sg, input logic [63:0] a, input logic [63:0] b,
                          input logic [TAG_W-1:0] tg, input int stall);
        logic [63:0] eq, er;
        logic        ez;
        int          n;
        ref_div(sg, a, b, eq, er, ez);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        in_signed = sg;
        dividend  = a;
        divisor   = b;
        in_tag    = tg;
        check_eq("in_ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", 64'(n), 64'd65);
        check_eq("quotient", quotient, eq);
        check_eq("remainder", remainder, er);
        check_eq("out_tag", 64'(out_tag), 64'(tg));
        check_eq("div_by_zero", 64'(div_by_zero), 64'(ez));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_eq("stall_out_valid", 64'(out_valid), 64'd1);
            check_eq("stall_in_ready", 64'(in_ready), 64'd0);
            check_eq("stall_quotient", quotient, eq);
            check_eq("stall_remainder", remainder, er);
            check_eq("stall_tag", 64'(out_tag), 64'(tg));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("release_out_valid", 64'(out_valid), 64'd0);
        check_eq("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] ra, rb;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_quotient", quotient, 64'd0);
        check_eq("rst_remainder", remainder, 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
        check_eq("rst_dbz", 64'(div_by_zero), 64'd0);

        // directed cases
        run_op(1'b0, 64'd100, 64'd7, 6'd5, 0);
        check_eq("dir_100_7_q", quotient, 64'd14);
        run_op(1'b1, -64'sd7, 64'd2, 6'd1, 0);
        check_eq("dir_m7_2_q", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1'b0, -64'sd7, 64'd2, 6'd2, 0);
        check_eq("dir_u_m7_2_q", quotient, 64'h7FFF_FFFF_FFFF_FFFC);
        run_op(1'b1, 64'h1234, 64'd0, 6'd3, 0);
        run_op(1'b0, 64'h1234, 64'd0, 6'd4, 0);
        run_op(1'b1, MIN64, '1, 6'd6, 0);
        run_op(1'b0, '1, 64'd1, 6'd7, 0);
        run_op(1'b1, 64'd1000, 64'd33, 6'd9, 10);

        // flush during BUSY
        in_valid = 1'b1; in_signed = 1'b0; dividend = 64'd50; divisor = 64'd3; in_tag = 6'd11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_in_ready", 64'(in_ready), 64'd1);
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        run_op(1'b1, 64'd77, -64'sd5, 6'd12, 0);

        // flush coincident with a request in IDLE
        in_valid = 1'b1; flush = 1'b1; dividend = 64'd9; divisor = 64'd2;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check_eq("flush_idle_no_accept", 64'(in_ready), 64'd1);
        repeat (70) @(posedge clk);
        #1;
        check_eq("flush_idle_no_result", 64'(out_valid), 64'd0);

        // reset mid-BUSY
        in_valid = 1'b1; dividend = 64'd500; divisor = 64'd7; in_tag = 6'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_eq("rst2_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst2_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst2_quotient", quotient, 64'd0);
        check_eq("rst2_remainder", remainder, 64'd0);
        check_eq("rst2_out_tag", 64'(out_tag), 64'd0);

        // random operands
        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 9) == 0) rb = 64'd0;
            run_op(1'($urandom_range(0, 1)), ra, rb, 6'($urandom_range(0, 63)),
                   $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
